mem_handle_responder: RTL and testbench
=======================================

Name: mem_handle_responder

Overview:
- Memory-side end of the mem_handle protocol.
- Services one initiator port (FPU operator) from a local word-addressed scratchpad. Returns data_load with a one-cycle done pulse.
- Writes with write_through set are also forwarded to a downstream backing-store port. For those writes, done waits for the downstream accept.
- Sits between each FPU operand handle and the memory subsystem.

Parameters:
- DEPTH, 1024, scratchpad words (power of two).
- ADDR_W, 32, width of ptr/region fields.
- LAT, 2, cycles from request acceptance to done (LAT ≥ 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- avail  in  1  initiator request valid
- r_en  in  1  read request
- w_en  in  1  write request
- ptr  in  ADDR_W  absolute word address
- data_store  in  32  write data
- write_through  in  1  forward this write downstream
- data_load  out  32  read data, valid while done=1
- done  out  1  one-cycle completion pulse
- cfg_begin  in  ADDR_W  region start, inclusive
- cfg_end  in  ADDR_W  region end, exclusive
- region_begin  out  ADDR_W  registered cfg_begin presented to initiator
- region_end  out  ADDR_W  registered cfg_end presented to initiator
- wt_valid  out  1  downstream write valid
- wt_addr  out  ADDR_W  downstream write address
- wt_data  out  32  downstream write data
- wt_ready  in  1  downstream accept
- err  out  1  sticky protocol/range error

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; done=0, data_load=0, wt_valid=0, wt_addr=0, wt_data=0, err=0.
  - region_begin=0, region_end=0.
  - Scratchpad contents retained, not cleared.
  - Reset mid-operation aborts the request with no done and no array write. A pending wt_valid drops the next cycle.
- Region registers: region_begin/region_end load from cfg_* every cycle while state=IDLE and avail=0. They are held otherwise.
- States: IDLE, ACCESS, WT_WAIT, RESP, RELEASE.
- IDLE:
  - Accept when avail=1 and (r_en|w_en)=1.
  - Latch ptr, data_store, write_through, op. Load counter with LAT-1. Go to ACCESS.
  - avail=1 with r_en=w_en=0 is ignored.
- ACCESS:
  - Counter decrements each cycle.
  - At 0, perform the access:
    - Read: data_load ← mem[ptr mod DEPTH].
    - Write: mem[ptr mod DEPTH] ← data.
  - Write with write_through=1 goes to WT_WAIT. Everything else goes to RESP.
  - LAT=1: ACCESS lasts one cycle.
- Latency: request sampled at edge k → done=1 during cycle k+LAT (no write-through).
- WT_WAIT:
  - wt_valid=1 with latched addr/data; stable until the cycle wt_ready=1.
  - On that edge wt_valid←0 and go to RESP.
  - Write-through done latency = LAT + cycles waiting on wt_ready.
- RESP: done=1 for exactly one cycle. data_load holds the read value (0 after a write or error). Go to RELEASE.
- RELEASE:
  - done=0. Wait for avail=0, then go to IDLE.
  - Guarantees one request produces one done even if the initiator holds avail one cycle past done.
- Range check uses the latched ptr against the region registers: valid iff region_begin ≤ ptr < region_end.
  - Out of range: no array write, no wt forward, data_load=0, done still pulses, err←1.
- r_en=1 and w_en=1 together: treated as error. No write, data_load=0, done pulses, err←1.
- err: sticky, cleared only by rst.
- ptr wraps modulo DEPTH for array indexing. The range check uses the full ADDR_W compare.
- region_end ≤ region_begin: every access is out of range.

Test Plan:
- LAT=2, region [0x10,0x20): write 0x3F800000 @0x10 without write_through → done 2 cycles after accept, wt_valid never asserts. Then read @0x10 → data_load=0x3F800000 with done, err=0.
- Write-through: write 0xDEADBEEF @0x1F with write_through=1, wt_ready held 0 for 3 cycles → wt_valid=1, wt_addr=0x1F, wt_data=0xDEADBEEF stable for 4 cycles. done comes the cycle after the wt_ready=1 edge.
- Out of range: read @0x20 → done pulses, data_load=0, err=1. A following valid read @0x11 still completes with err staying 1.
- r_en=w_en=1 @0x12 holding 0x5 → done, err=1, mem[0x12] still 0x5.
- Initiator keeps avail=1 two cycles after done → exactly one done, no second access. A new request is accepted only after avail drops.
- Assert rst during ACCESS of a write @0x13 (old 0x7, new 0x9) → no done, state IDLE, err=0, read @0x13 afterwards returns 0x7.

Source files
------------

// File: rtl/mem_handle_responder.sv
// Memory-side responder for the mem_handle protocol: one initiator, a local
// word scratchpad, optional write-through forwarding to a backing store.
module mem_handle_responder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avail,
  input  logic              r_en,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] ptr,
  input  logic [31:0]       data_store,
  input  logic              write_through,
  output logic [31:0]       data_load,
  output logic              done,
  input  logic [ADDR_W-1:0] cfg_begin,
  input  logic [ADDR_W-1:0] cfg_end,
  output logic [ADDR_W-1:0] region_begin,
  output logic [ADDR_W-1:0] region_end,
  output logic              wt_valid,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [31:0]       wt_data,
  input  logic              wt_ready,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_WT_WAIT = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_data;
  logic              r_rd;
  logic              r_wr;
  logic              r_wt;
  logic [31:0]       r_mem [DEPTH];

  logic              w_fire;
  logic              w_in_range;
  logic              w_op_err;
  logic              w_ok;
  logic              w_mem_we;
  logic              w_fwd;
  logic [IDX_W-1:0]  w_idx;

  // Range check uses the full pointer; only the array index wraps.
  assign w_in_range = (r_ptr >= region_begin) && (r_ptr < region_end);
  assign w_op_err   = r_rd & r_wr;
  assign w_ok       = w_in_range & ~w_op_err;
  assign w_fire     = (r_state == S_ACCESS) && (r_cnt == '0);
  assign w_idx      = r_ptr[IDX_W-1:0];
  assign w_mem_we   = w_fire & r_wr & w_ok & ~rst;
  assign w_fwd      = r_wr & r_wt & w_ok;

  // Scratchpad is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= r_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_data       <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_wt         <= 1'b0;
      data_load    <= '0;
      done         <= 1'b0;
      wt_valid     <= 1'b0;
      wt_addr      <= '0;
      wt_data      <= '0;
      err          <= 1'b0;
      region_begin <= '0;
      region_end   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!avail) begin
            region_begin <= cfg_begin;
            region_end   <= cfg_end;
          end
          if (avail && (r_en || w_en)) begin
            r_ptr   <= ptr;
            r_data  <= data_store;
            r_wt    <= write_through;
            r_rd    <= r_en;
            r_wr    <= w_en;
            r_cnt   <= CNT_W'(LAT - 1);
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            data_load <= (r_rd && w_ok) ? r_mem[w_idx] : 32'd0;
            if (!w_ok) err <= 1'b1;
            if (w_fwd) begin
              wt_valid <= 1'b1;
              wt_addr  <= r_ptr;
              wt_data  <= r_data;
              r_state  <= S_WT_WAIT;
            end else begin
              done    <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_WT_WAIT: begin
          if (wt_ready) begin
            wt_valid <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          done    <= 1'b0;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Hold off until avail drops so a lingering request is not replayed.
          if (!avail) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handle_responder.sv
// Scoreboard bench for mem_handle_responder: expected responses are queued at
// request time and popped by a monitor when done pulses.
module tb_mem_handle_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        avail = 1'b0, r_en = 1'b0, w_en = 1'b0, write_through = 1'b0;
  logic [31:0] ptr = '0, data_store = '0;
  logic [31:0] data_load;
  logic        done;
  logic [31:0] cfg_begin = 32'h10, cfg_end = 32'h20;
  logic [31:0] region_begin, region_end;
  logic        wt_valid;
  logic [31:0] wt_addr, wt_data;
  logic        wt_ready = 1'b0;
  logic        err;

  mem_handle_responder #(.DEPTH(1024), .ADDR_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .avail(avail), .r_en(r_en), .w_en(w_en),
    .ptr(ptr), .data_store(data_store), .write_through(write_through),
    .data_load(data_load), .done(done), .cfg_begin(cfg_begin), .cfg_end(cfg_end),
    .region_begin(region_begin), .region_end(region_end),
    .wt_valid(wt_valid), .wt_addr(wt_addr), .wt_data(wt_data),
    .wt_ready(wt_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data_load", data_load, e.d);
        chk("err", {31'd0, err}, {31'd0, e.e});
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; avail = 1'b0; r_en = 1'b0; w_en = 1'b0; wt_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dload", data_load, 32'd0);
    chk("rst_wtv", {31'd0, wt_valid}, 32'd0);
    chk("rst_wtaddr", wt_addr, 32'd0);
    chk("rst_wtdata", wt_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rbeg", region_begin, 32'd0);
    chk("rst_rend", region_end, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reg_beg", region_begin, 32'h10);
    chk("reg_end", region_end, 32'h20);
  endtask

  // One request: queue the expectation, service wt_ready after wt_valid has
  // been up for 3 stalled cycles, keep avail for `hold` cycles after done.
  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic wt, input logic [31:0] ed,
                     input logic ee, input int elat, input int ewt, input int hold);
    int n, wtn;
    logic got;
    repeat (2) @(posedge clk);
    #1;
    avail = 1'b1; r_en = rd; w_en = wr; ptr = a; data_store = d; write_through = wt;
    sb.push_back('{d: ed, e: ee, lat: elat, acc: cyc + 1});
    n = 0; wtn = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (wt_valid) begin
        wtn++;
        chk("wt_addr", wt_addr, a);
        chk("wt_data", wt_data, d);
        wt_ready = (wtn >= 4);
      end
      if (done) got = 1'b1;
    end
    wt_ready = 1'b0;
    chk("timeout", {31'd0, got}, 32'd1);
    chk("wt_cycles", 32'(wtn), 32'(ewt));
    repeat (hold) @(negedge clk);
    avail = 1'b0; r_en = 1'b0; w_en = 1'b0; write_through = 1'b0;
  endtask

  initial begin
    int dc0;
    do_reset();

    req(0, 1, 32'h10, 32'h3F800000, 0, 32'h0, 0, LAT, 0, 0);
    req(1, 0, 32'h10, 32'h0, 0, 32'h3F800000, 0, LAT, 0, 0);
    // Write-through: 4 wt_valid cycles, done the cycle after the accepting edge
    req(0, 1, 32'h1F, 32'hDEADBEEF, 1, 32'h0, 0, LAT + 4, 4, 0);
    req(1, 0, 32'h1F, 32'h0, 0, 32'hDEADBEEF, 0, LAT, 0, 0);
    req(0, 1, 32'h11, 32'hAAAA5555, 0, 32'h0, 0, LAT, 0, 0);
    req(0, 1, 32'h12, 32'h5, 0, 32'h0, 0, LAT, 0, 0);
    req(0, 1, 32'h13, 32'h7, 0, 32'h0, 0, LAT, 0, 0);

    // Reset during ACCESS of a write to 0x13
    repeat (2) @(posedge clk);
    #1;
    dc0 = done_cnt;
    avail = 1'b1; w_en = 1'b1; ptr = 32'h13; data_store = 32'h9;
    @(negedge clk);
    rst = 1'b1; avail = 1'b0; w_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_done", 32'(done_cnt - dc0), 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_wtv", {31'd0, wt_valid}, 32'd0);
    req(1, 0, 32'h13, 32'h0, 0, 32'h7, 0, LAT, 0, 0);

    // r_en and w_en together
    req(1, 1, 32'h12, 32'h77, 0, 32'h0, 1, LAT, 0, 0);
    req(1, 0, 32'h12, 32'h0, 0, 32'h5, 1, LAT, 0, 0);

    do_reset();
    req(1, 0, 32'h20, 32'h0, 0, 32'h0, 1, LAT, 0, 0);
    req(0, 1, 32'h20, 32'h1234, 1, 32'h0, 1, LAT, 0, 0);
    // 0x410 aliases 0x10 in the array but is outside the region
    req(1, 0, 32'h410, 32'h0, 0, 32'h0, 1, LAT, 0, 0);
    req(1, 0, 32'h11, 32'h0, 0, 32'hAAAA5555, 1, LAT, 0, 0);

    dc0 = done_cnt;
    req(1, 0, 32'h10, 32'h0, 0, 32'h3F800000, 1, LAT, 0, 2);
    repeat (4) @(negedge clk);
    chk("hold_once", 32'(done_cnt - dc0), 32'd1);
    req(1, 0, 32'h1F, 32'h0, 0, 32'hDEADBEEF, 1, LAT, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
